pio_key_debounced: RTL and testbench



---
 rtl/pio_key_debounced.sv | 62 ++++++
 tb/tb_pio_key_debounced.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pio_key_debounced.sv
// pio_key_debounced: WIDTH debounced inputs with selectable edge capture and masked irq on an Avalon-MM slave.
module pio_key_debounced #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0] sync1, sync2, db, mask, cap, rise, any, change, qual, clr, wd, rd_sel;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic we;
  always_comb begin
    we = chipselect & ~write_n;
    wd = writedata[WIDTH-1:0];
    change = '0;
    for (int k = 0; k < WIDTH; k++)
      change[k] = (sync2[k] != db[k]) && (cnt[k] == CW'(DEBOUNCE_CYCLES - 1));
    // sync2 is the value db takes on for any bit that changes this cycle
    qual = change & (any | (rise & sync2) | (~rise & ~sync2));
    clr = (we && address == 3'd3) ? wd : '0;
    rd_sel = address == 3'd0 ? db :
             address == 3'd1 ? sync2 :
             address == 3'd2 ? mask :
             address == 3'd3 ? cap :
             address == 3'd4 ? rise :
             address == 3'd5 ? any : '0;
    irq = |(cap & mask);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
      db <= RESET_LEVEL;
      cnt <= '0;
      mask <= '0;
      cap <= '0;
      rise <= '0;
      any <= '0;
      readdata <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      for (int k = 0; k < WIDTH; k++)
        cnt[k] <= (sync2[k] == db[k] || change[k]) ? '0 : cnt[k] + 1'b1;
      db <= db ^ change;
      cap <= (cap & ~clr) | qual;
      if (we && address == 3'd2) mask <= wd;
      if (we && address == 3'd4) rise <= wd;
      if (we && address == 3'd5) any <= wd;
      readdata <= 32'(rd_sel);
    end
  end
endmodule

// File: tb/tb_pio_key_debounced.sv
// tb_pio_key_debounced: directed stimulus checked against a sliding-window reference model plus literal expectations.
module tb_pio_key_debounced;
  localparam int W = 4;
  localparam int D = 4;
  localparam logic [W-1:0] RL = '1;
  logic clk = 0;
  logic reset = 1;
  logic [2:0] address = 0;
  logic chipselect = 0;
  logic write_n = 1;
  logic [31:0] writedata = 0;
  logic [W-1:0] in_port = '1;
  logic [31:0] readdata;
  logic irq;
  int n_chk = 0;
  int n_fail = 0;
  pio_key_debounced #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(RL)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );
  always #5 clk = ~clk;
  // Model: p[k] holds in_port sampled k+1 edges ago, so p[1] is the synchronised value and
  // a bit is accepted once the last D synchronised samples all disagree with the debounced state.
  logic [W-1:0] p [0:D];
  logic [W-1:0] m_db, m_cap, m_mask, m_rise, m_any, fl, q, wv, nd;
  logic [31:0] m_rd;
  bit started = 0;
  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      for (int j = 0; j <= D; j++) p[j] = RL;
      m_db = RL; m_cap = 0; m_mask = 0; m_rise = 0; m_any = 0; m_rd = 0;
    end else begin
      case (address)
        3'd0: m_rd = {28'd0, m_db};
        3'd1: m_rd = {28'd0, p[1]};
        3'd2: m_rd = {28'd0, m_mask};
        3'd3: m_rd = {28'd0, m_cap};
        3'd4: m_rd = {28'd0, m_rise};
        3'd5: m_rd = {28'd0, m_any};
        default: m_rd = 0;
      endcase
      fl = '1;
      for (int j = 1; j <= D; j++) fl &= p[j] ^ m_db;
      nd = m_db ^ fl;
      q = 0;
      for (int b = 0; b < W; b++)
        if (fl[b] && (m_any[b] || (m_rise[b] == nd[b]))) q[b] = 1;
      wv = (chipselect && !write_n) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~((address == 3'd3) ? wv : '0)) | q;
      m_db = nd;
      if (chipselect && !write_n) begin
        if (address == 3'd2) m_mask = wv;
        if (address == 3'd4) m_rise = wv;
        if (address == 3'd5) m_any = wv;
      end
      for (int j = D; j >= 1; j--) p[j] = p[j-1];
      p[0] = in_port;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (started) begin
    chk("model_readdata", readdata, m_rd);
    chk("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    step(1);
    chipselect = 0; write_n = 1; writedata = 0;
  endtask
  task automatic rd(input logic [2:0] a, input string name, input logic [31:0] exp);
    address = a;
    step(1);
    chk(name, readdata, exp);
  endtask
  initial begin
    step(3);
    reset = 0;
    rd(0, "reset_data", 32'hF);
    chk("reset_irq", {31'd0, irq}, 0);
    for (int a = 2; a <= 5; a++) rd(3'(a), "reset_regs", 0);
    // falling edge on bit 0, accepted at the 6th edge
    wr(2, 32'hFFFF_FFF1);
    address = 0;
    in_port = 4'hE;
    step(5);
    chk("irq_before_accept", {31'd0, irq}, 0);
    step(1);
    chk("irq_at_accept", {31'd0, irq}, 1);
    chk("data_old_at_accept", readdata, 32'hF);
    step(1);
    chk("data_after_accept", readdata, 32'hE);
    rd(3, "cap_bit0", 32'h1);
    // 3-cycle glitch on bit 1 is rejected
    address = 1;
    in_port = 4'hC;
    step(3);
    in_port = 4'hE;
    chk("raw_pulse", readdata, 32'hC);
    step(2);
    chk("raw_pulse_end", readdata, 32'hC);
    step(1);
    chk("raw_restored", readdata, 32'hE);
    step(4);
    rd(0, "glitch_data", 32'hE);
    rd(3, "glitch_cap", 32'h1);
    // both-edge capture on bit 2 with a clear in between
    wr(5, 32'h4);
    in_port = 4'hA;
    step(8);
    rd(3, "any_fall_cap", 32'h5);
    wr(3, 32'h4);
    rd(3, "any_clear_cap", 32'h1);
    in_port = 4'hE;
    step(8);
    rd(3, "any_rise_cap", 32'h5);
    // clear and new falling edge on bit 0 in the same cycle: set wins
    in_port = 4'hF;
    step(8);
    rd(0, "bit0_released", 32'hF);
    in_port = 4'hE;
    step(5);
    wr(3, 32'h1);
    chk("set_wins_irq", {31'd0, irq}, 1);
    rd(3, "set_wins_cap", 32'h5);
    wr(3, 32'h2);
    rd(3, "w1c_other_bit", 32'h5);
    // reset while bit 3 is mid-count
    in_port = 4'h6;
    step(4);
    reset = 1;
    step(1);
    reset = 0;
    in_port = 4'hF;
    chk("midreset_irq", {31'd0, irq}, 0);
    rd(0, "midreset_data", 32'hF);
    rd(3, "midreset_cap", 32'h0);
    step(20);
    rd(3, "post_reset_cap", 32'h0);
    chk("post_reset_irq", {31'd0, irq}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
